// File: rtl/jtag_pkg.sv
// jtag_pkg: op codes, FSM states and LSB-first TMS patterns shared by the JTAG shift engine.
package jtag_pkg;
  typedef enum logic [1:0] {OP_DR = 2'd0, OP_IR = 2'd1, OP_RST = 2'd2, OP_RSV = 2'd3} op_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HEAD, S_SHIFT, S_TAIL, S_RTAP, S_DONE} state_e;
  localparam logic [2:0] DR_HDR   = 3'b001;
  localparam logic [3:0] IR_HDR   = 4'b0011;
  localparam logic [1:0] TAIL_PAT = 2'b01;
  localparam logic [5:0] RST_PAT  = 6'b011111;
  localparam logic [2:0] DR_LEN   = 3'd3;
  localparam logic [2:0] IR_LEN   = 3'd4;
  localparam logic [2:0] TAIL_LEN = 3'd2;
  localparam logic [2:0] RST_LEN  = 3'd6;
  // {length, zero-extended pattern} for the next TMS-only segment
  function automatic logic [8:0] seq_sel(input op_e op, input logic tail);
    return tail ? {TAIL_LEN, 4'b0, TAIL_PAT} :
           op == OP_RST ? {RST_LEN, RST_PAT} :
           op == OP_IR ? {IR_LEN, 2'b0, IR_HDR} : {DR_LEN, 3'b0, DR_HDR};
  endfunction
endpackage

// File: rtl/jtag_tms_seq.sv
// jtag_tms_seq: loadable TMS pattern shifter; last is high once every pattern bit has been issued.
module jtag_tms_seq
  import jtag_pkg::*;
(
  input  logic       FASTCLK,
  input  logic       clr_pload,
  input  logic       ld,
  input  logic       adv,
  input  logic [5:0] pat,
  input  logic [2:0] len,
  output logic       tms,
  output logic       last
);
  logic [5:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  always_comb begin
    sr_d  = ld ? pat : adv ? sr_q >> 1 : sr_q;
    cnt_d = ld ? len : adv ? cnt_q - 3'd1 : cnt_q;
  end
  always_ff @(posedge FASTCLK or posedge clr_pload)
    if (clr_pload) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  assign tms  = sr_q[0];
  assign last = cnt_q == 3'd0;
endmodule

// File: rtl/jtag_shift_engine_nch.sv
// jtag_shift_engine_nch: multi-chain JTAG master shifting one IR/DR/reset command per handshake.
module jtag_shift_engine_nch
  import jtag_pkg::*;
#(
  parameter int DW  = 16,
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int NBW = 5,
  parameter int TMR = 0
) (
  input  logic             FASTCLK,
  input  logic             clr_pload,
  input  logic             TCK_EN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_hdr,
  input  logic             cmd_tail,
  input  logic [CHW-1:0]   cmd_chan,
  input  logic [NBW-1:0]   cmd_nbits,
  input  logic [DW-1:0]    cmd_tdi,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DW-1:0]    rd_data,
  output logic [NCH-1:0]   TCK,
  output logic [NCH-1:0]   TMS,
  output logic [NCH-1:0]   TDI,
  input  logic [NCH-1:0]   TDO
);
  localparam int CW = $bits(state_e) + 1 + NBW;
  localparam int NR = TMR != 0 ? 3 : 1;
  state_e st_q, st_d;
  op_e op_q, op_d;
  logic ph_q, ph_d, hdr_q, hdr_d, tail_q, tail_d, err_q, err_d;
  logic tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [NBW-1:0] bc_q, bc_d, nb_q, nb_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [DW-1:0] tsr_q, tsr_d, cap_q, cap_d, rd_q, rd_d;
  logic [CW-1:0] ctl_q [NR];
  logic [CW-1:0] ctl;
  logic act, exh, tick_a, tick_b, bad;
  logic seq_ld, seq_adv, seq_tms, seq_last;
  logic [5:0] seq_pat;
  logic [2:0] seq_len;
  assign act    = st_q inside {S_HEAD, S_SHIFT, S_TAIL, S_RTAP};
  assign exh    = st_q == S_SHIFT ? bc_q == '0 : seq_last;
  assign tick_a = act && TCK_EN && !ph_q;
  assign tick_b = act && TCK_EN && ph_q;
  assign bad    = op_e'(cmd_op) == OP_RSV || cmd_nbits == '0 || cmd_nbits > NBW'(DW);
  assign seq_ld  = st_q == S_LOAD || (tick_b && st_q == S_SHIFT && exh && tail_q);
  assign seq_adv = tick_a && st_q != S_SHIFT && !exh;
  assign {seq_len, seq_pat} = seq_sel(op_q, st_q == S_SHIFT);
  jtag_tms_seq u_seq (
    .FASTCLK(FASTCLK), .clr_pload(clr_pload), .ld(seq_ld), .adv(seq_adv),
    .pat(seq_pat), .len(seq_len), .tms(seq_tms), .last(seq_last)
  );
  always_comb begin
    st_d = st_q; op_d = op_q; ph_d = ph_q; hdr_d = hdr_q; tail_d = tail_q; err_d = 1'b0;
    tck_d = tck_q; tms_d = tms_q; tdi_d = tdi_q; bc_d = bc_q; nb_d = nb_q; ch_d = ch_q;
    tsr_d = tsr_q; cap_d = cap_q; rd_d = rd_q;
    if (st_q == S_IDLE && cmd_valid) begin
      if (bad) err_d = 1'b1;
      else begin
        st_d = S_LOAD; op_d = op_e'(cmd_op); hdr_d = cmd_hdr; tail_d = cmd_tail; ch_d = cmd_chan;
        nb_d = cmd_nbits; bc_d = cmd_nbits; tsr_d = cmd_tdi; cap_d = '0;
        if (op_e'(cmd_op) != OP_RST) rd_d = '0;
      end
    end
    if (st_q == S_LOAD) st_d = op_q == OP_RST ? S_RTAP : hdr_q ? S_HEAD : S_SHIFT;
    if (st_q == S_DONE) st_d = S_IDLE;
    // an exhausted segment seen on tick A is always the final one: drop TCK and finish
    if (tick_a) begin
      tck_d = 1'b0;
      ph_d  = 1'b1;
      if (exh) begin
        st_d = S_DONE; ph_d = 1'b0; tms_d = 1'b0; tdi_d = 1'b0;
        if (op_q != OP_RST) rd_d = cap_q >> (DW - int'(nb_q));
      end else if (st_q == S_SHIFT) begin
        tms_d = tail_q && bc_q == NBW'(1); tdi_d = tsr_q[0]; tsr_d = tsr_q >> 1; bc_d = bc_q - NBW'(1);
      end else begin
        tms_d = seq_tms; tdi_d = 1'b0;
      end
    end
    if (tick_b) begin
      tck_d = 1'b1;
      ph_d  = 1'b0;
      if (st_q == S_SHIFT) cap_d = {TDO[ch_q], cap_q[DW-1:1]};
      if (exh && st_q == S_HEAD) st_d = S_SHIFT;
      if (exh && st_q == S_SHIFT && tail_q) st_d = S_TAIL;
    end
  end
  always_ff @(posedge FASTCLK or posedge clr_pload)
    if (clr_pload) for (int i = 0; i < NR; i++) ctl_q[i] <= '0;
    else for (int i = 0; i < NR; i++) ctl_q[i] <= {st_d, ph_d, bc_d};
  generate
    if (NR == 3) begin : g_tmr
      assign ctl = (ctl_q[0] & ctl_q[1]) | (ctl_q[0] & ctl_q[2]) | (ctl_q[1] & ctl_q[2]);
    end else begin : g_one
      assign ctl = ctl_q[0];
    end
  endgenerate
  assign st_q = state_e'(ctl[CW-1 -: $bits(state_e)]);
  assign ph_q = ctl[NBW];
  assign bc_q = ctl[NBW-1:0];
  always_ff @(posedge FASTCLK or posedge clr_pload)
    if (clr_pload) begin
      op_q <= OP_DR; hdr_q <= 1'b0; tail_q <= 1'b0; err_q <= 1'b0;
      tck_q <= 1'b0; tms_q <= 1'b0; tdi_q <= 1'b0; nb_q <= '0; ch_q <= '0;
      tsr_q <= '0; cap_q <= '0; rd_q <= '0;
    end else begin
      op_q <= op_d; hdr_q <= hdr_d; tail_q <= tail_d; err_q <= err_d;
      tck_q <= tck_d; tms_q <= tms_d; tdi_q <= tdi_d; nb_q <= nb_d; ch_q <= ch_d;
      tsr_q <= tsr_d; cap_q <= cap_d; rd_q <= rd_d;
    end
  assign cmd_ready = st_q == S_IDLE;
  assign busy      = st_q == S_LOAD || act;
  assign done      = st_q == S_DONE;
  assign err       = err_q;
  assign rd_data   = rd_q;
  assign TCK = {{(NCH-1){1'b0}}, tck_q} << ch_q;
  assign TMS = {{(NCH-1){1'b0}}, tms_q} << ch_q;
  assign TDI = {{(NCH-1){1'b0}}, tdi_q} << ch_q;
endmodule

// File: tb/tb_jtag_shift_engine_nch.sv
// tb_jtag_shift_engine_nch: random and directed commands scored against a bit-sequence reference model.
module tb_jtag_shift_engine_nch;
  localparam int DW = 16, NCH = 4, CHW = 2, NBW = 5;
  logic FASTCLK = 0, clr_pload = 1, TCK_EN = 0, cmd_valid = 0, cmd_hdr = 0, cmd_tail = 0;
  logic [1:0] cmd_op = 0;
  logic [CHW-1:0] cmd_chan = 0;
  logic [NBW-1:0] cmd_nbits = 0;
  logic [DW-1:0] cmd_tdi = 0, rd_data;
  logic cmd_ready, busy, done, err;
  logic [NCH-1:0] TCK, TMS, TDI, TDO;
  int tdo_mode = 0;
  bit tick_run = 1;
  assign TDO = tdo_mode == 0 ? TDI : tdo_mode == 1 ? ~TDI : '0;
  typedef struct {
    bit is_err;
    logic [DW-1:0] rd;
    int n;
    bit [31:0] tms;
    bit [31:0] tdi;
    int chan;
  } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0, ntck = 0, stray = 0;
  bit [31:0] got_tms = 0, got_tdi = 0;
  logic [NCH-1:0] tck_prev = 0;
  logic [DW-1:0] model_rd = 0;
  always #5 FASTCLK = ~FASTCLK;
  jtag_shift_engine_nch #(.DW(DW), .NCH(NCH), .CHW(CHW), .NBW(NBW), .TMR(0)) dut (
    .FASTCLK(FASTCLK), .clr_pload(clr_pload), .TCK_EN(TCK_EN), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_hdr(cmd_hdr), .cmd_tail(cmd_tail),
    .cmd_chan(cmd_chan), .cmd_nbits(cmd_nbits), .cmd_tdi(cmd_tdi), .busy(busy), .done(done),
    .err(err), .rd_data(rd_data), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask
  initial forever begin
    @(negedge FASTCLK);
    TCK_EN = tick_run && ($urandom_range(0, 2) == 0);
  end
  // monitor: record TMS/TDI at every TCK rise on the active chain, score on done/err
  always @(negedge FASTCLK) begin
    int ch;
    exp_t e;
    if (clr_pload) begin
      ntck = 0; stray = 0; got_tms = 0; got_tdi = 0; tck_prev = '0;
    end else begin
      ch = exp_q.size() != 0 ? exp_q[0].chan : -1;
      for (int c = 0; c < NCH; c++) begin
        if (c != ch && (TCK[c] | TMS[c] | TDI[c])) stray++;
        if (c == ch && TCK[c] && !tck_prev[c]) begin
          if (ntck < 32) begin got_tms[ntck] = TMS[c]; got_tdi[ntck] = TDI[c]; end
          ntck++;
        end
      end
      tck_prev = TCK;
      if (done || err) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_completion: got done=%b err=%b expected none", done, err);
        end else begin
          e = exp_q.pop_front();
          check("kind", {30'b0, done, err}, e.is_err ? 32'd1 : 32'd2);
          check("tck_count", ntck, e.n);
          check("tms_seq", got_tms, e.tms);
          check("tdi_seq", got_tdi, e.tdi);
          check("rd_data", {16'b0, rd_data}, {16'b0, e.rd});
          check("busy_at_end", {31'b0, busy}, 0);
          check("tck_low_at_end", {28'b0, TCK}, 0);
          check("stray_chain", stray, 0);
        end
        ntck = 0; stray = 0; got_tms = 0; got_tdi = 0;
      end
    end
  end
  task automatic do_reset();
    @(negedge FASTCLK);
    clr_pload = 1;
    cmd_valid = 0;
    exp_q.delete();
    repeat (2) @(negedge FASTCLK);
    clr_pload = 0;
    model_rd = '0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(negedge FASTCLK); k++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got no completion, expected done/err within 3000 cycles");
      do_reset();
    end
  endtask
  task automatic issue(input int op, input int hdr, input int tail, input int ch, input int nb,
                       input logic [DW-1:0] d, input int mode, input bit wait_done);
    exp_t e;
    int k = 0, n = 0;
    logic [DW-1:0] r = '0;
    @(negedge FASTCLK);
    while (!cmd_ready && k < 3000) begin @(negedge FASTCLK); k++; end
    check("ready_before_issue", {31'b0, cmd_ready}, 1);
    check("rd_hold", {16'b0, rd_data}, {16'b0, model_rd});
    e.is_err = 0; e.rd = model_rd; e.n = 0; e.tms = 0; e.tdi = 0; e.chan = ch;
    if (op == 3 || nb == 0 || nb > DW) e.is_err = 1;
    else if (op == 2) begin
      for (int i = 0; i < 6; i++) e.tms[i] = i < 5;
      e.n = 6;
    end else begin
      if (hdr != 0) begin
        int hl = op == 1 ? 4 : 3;
        for (int i = 0; i < hl; i++) begin e.tms[n] = i < hl - 2; n++; end
      end
      for (int i = 0; i < nb; i++) begin
        e.tms[n] = tail != 0 && i == nb - 1;
        e.tdi[n] = d[i];
        r[i] = mode == 0 ? d[i] : mode == 1 ? ~d[i] : 1'b0;
        n++;
      end
      if (tail != 0) begin e.tms[n] = 1; n += 2; end
      e.n = n;
      model_rd = r;
      e.rd = r;
    end
    tdo_mode = mode;
    cmd_op = op[1:0]; cmd_hdr = hdr[0]; cmd_tail = tail[0]; cmd_chan = ch[CHW-1:0];
    cmd_nbits = nb[NBW-1:0]; cmd_tdi = d; cmd_valid = 1;
    exp_q.push_back(e);
    @(posedge FASTCLK);
    #1 cmd_valid = 0;
    if (wait_done) wait_idle();
  endtask
  initial begin
    int k, t0;
    repeat (3) @(negedge FASTCLK);
    check("rst_ready", {31'b0, cmd_ready}, 1);
    check("rst_flags", {29'b0, busy, done, err}, 0);
    check("rst_rd", {16'b0, rd_data}, 0);
    check("rst_pins", {20'b0, TCK, TMS, TDI}, 0);
    clr_pload = 0;
    issue(0, 1, 1, 2, 8, 16'h00A5, 0, 1);
    issue(1, 1, 1, 0, 5, 16'h001F, 0, 1);
    issue(2, 0, 0, 3, 4, 16'h0000, 0, 1);
    // second command while busy must be dropped; TCK_EN low must freeze progress
    issue(0, 0, 1, 1, 12, 16'h3C5A, 1, 0);
    repeat (4) @(negedge FASTCLK);
    check("ready_while_busy", {31'b0, cmd_ready}, 0);
    cmd_op = 1; cmd_chan = 3; cmd_nbits = 4; cmd_valid = 1;
    repeat (3) @(negedge FASTCLK);
    cmd_valid = 0;
    tick_run = 0;
    repeat (2) @(negedge FASTCLK);
    t0 = ntck;
    repeat (60) @(negedge FASTCLK);
    check("freeze_tck", ntck, t0);
    check("freeze_busy", {31'b0, busy}, 1);
    tick_run = 1;
    wait_idle();
    repeat (30) @(negedge FASTCLK);
    issue(0, 1, 0, 2, 0, 16'h1234, 0, 1);
    issue(3, 1, 1, 1, 8, 16'h00FF, 0, 1);
    issue(1, 0, 0, 0, 17, 16'hFFFF, 0, 1);
    // reset in the middle of a 16-bit shift
    issue(0, 0, 0, 1, 16, 16'hFFFF, 2, 0);
    k = 0;
    while (ntck < 7 && k < 3000) begin @(negedge FASTCLK); k++; end
    check("seven_tck_reached", {31'b0, ntck >= 7}, 1);
    clr_pload = 1;
    exp_q.delete();
    @(negedge FASTCLK);
    check("midrst_ready", {31'b0, cmd_ready}, 1);
    check("midrst_flags", {29'b0, busy, done, err}, 0);
    check("midrst_rd", {16'b0, rd_data}, 0);
    check("midrst_pins", {20'b0, TCK, TMS, TDI}, 0);
    @(negedge FASTCLK);
    clr_pload = 0;
    model_rd = '0;
    issue(0, 0, 0, 2, 16, 16'hFFFF, 0, 1);
    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 3);
      int nb = op == 2 ? $urandom_range(1, DW) : $urandom_range(0, DW + 2);
      issue(op, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NCH - 1), nb,
            DW'($urandom), $urandom_range(0, 2), 1);
    end
    repeat (20) @(negedge FASTCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected finish before 3000000 time units");
    $fatal(1, "watchdog");
  end
endmodule
